// File: rtl/dffram_wb_pkg.sv
// Shared types and address-geometry helpers for the DFFRAM Wishbone responder.
package dffram_wb_pkg;

    // Bus-side sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } wb_state_t;

    // Each bank holds 16 words, so the word address needs 4 bits plus the bank select.
    function automatic int calc_aw(input int banks);
        return $clog2(banks) + 4;
    endfunction

    // The bus carries byte addresses; the word index starts above the byte offset.
    localparam int ADR_LO_BIT = 2;

    // Highest byte-address bit that still lands inside the RAM.
    function automatic int adr_hi_bit(input int aw);
        return aw + 1;
    endfunction

    // Geometry of the default two-bank configuration.
    localparam int DEFAULT_BANKS  = 2;
    localparam int DEFAULT_AW     = calc_aw(DEFAULT_BANKS);
    localparam int DEFAULT_ADR_HI = adr_hi_bit(DEFAULT_AW);

endpackage

// File: rtl/dffram_wb_responder.sv
// Wishbone classic slave that sequences a single-port DFFRAM macro port,
// one transaction at a time, absorbing the macro's one-cycle read latency.
module dffram_wb_responder
    import dffram_wb_pkg::*;
#(
    parameter  int WSIZE = 4,
    parameter  int BANKS = 2,
    localparam int DW    = WSIZE * 8,
    localparam int AW    = calc_aw(BANKS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [WSIZE-1:0] wb_sel_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [DW-1:0]    wb_dat_i,
    output logic [DW-1:0]    wb_dat_o,
    output logic             wb_ack_o,
    output logic             EN0,
    output logic [WSIZE-1:0] WE0,
    output logic [AW-1:0]    A0,
    output logic [DW-1:0]    Di0,
    input  logic [DW-1:0]    Do0
);

    localparam int ADR_HI = adr_hi_bit(AW);

    wb_state_t        state_reg, state_next;
    logic             is_wr_reg, is_wr_next;
    logic             en0_reg,   en0_next;
    logic [WSIZE-1:0] we0_reg,   we0_next;
    logic [AW-1:0]    a0_reg,    a0_next;
    logic [DW-1:0]    di0_reg,   di0_next;
    logic [DW-1:0]    dat_reg,   dat_next;

    // Byte offset and the aliased upper address bits play no part in the access.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:ADR_HI+1], wb_adr_i[ADR_LO_BIT-1:0]};

    // State and RAM-port registers; reset clears every output immediately so an
    // in-flight write that has not reached the RAM edge is dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            is_wr_reg <= 1'b0;
            en0_reg   <= 1'b0;
            we0_reg   <= '0;
            a0_reg    <= '0;
            di0_reg   <= '0;
            dat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            is_wr_reg <= is_wr_next;
            en0_reg   <= en0_next;
            we0_reg   <= we0_next;
            a0_reg    <= a0_next;
            di0_reg   <= di0_next;
            dat_reg   <= dat_next;
        end
    end

    // Next-state and next-port-value logic; bus inputs are only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        is_wr_next = is_wr_reg;
        en0_next   = en0_reg;
        we0_next   = we0_reg;
        a0_next    = a0_reg;
        di0_next   = di0_reg;
        dat_next   = dat_reg;

        case (state_reg)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    a0_next    = wb_adr_i[ADR_HI:ADR_LO_BIT];
                    di0_next   = wb_dat_i;
                    we0_next   = wb_we_i ? wb_sel_i : '0;
                    en0_next   = 1'b1;
                    is_wr_next = wb_we_i;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // The macro samples its port on the edge leaving this state.
                en0_next   = 1'b0;
                we0_next   = '0;
                state_next = is_wr_reg ? ACK : RDWAIT;
            end
            RDWAIT: begin
                // Do0 became valid after the ACCESS edge; capture it for the bus.
                dat_next   = Do0;
                state_next = ACK;
            end
            ACK: begin
                // Always pass through IDLE so a held strobe is not re-accepted at once.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Acknowledge only while the master still owns the cycle.
    assign wb_ack_o = (state_reg == ACK) && wb_cyc_i;
    assign wb_dat_o = dat_reg;
    assign EN0      = en0_reg;
    assign WE0      = we0_reg;
    assign A0       = a0_reg;
    assign Di0      = di0_reg;

endmodule

// File: tb/tb_dffram_wb_responder.sv
// Directed bench for dffram_wb_responder with a behavioural single-port DFFRAM.
module tb_dffram_wb_responder;
    import dffram_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        en0;
    logic [3:0]  we0;
    logic [4:0]  a0;
    logic [31:0] di0;
    logic [31:0] do0;
    logic [31:0] mem [0:31];

    int checks   = 0;
    int failures = 0;

    dffram_wb_responder dut (
        .CLK      (clk),
        .RST      (rst),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .EN0      (en0),
        .WE0      (we0),
        .A0       (a0),
        .Di0      (di0),
        .Do0      (do0)
    );

    always #5 clk = ~clk;

    // Behavioural DFFRAM: byte-masked write, registered read.
    always @(posedge clk) begin
        if (en0) begin
            for (int b = 0; b < 4; b++)
                if (we0[b]) mem[a0][8*b +: 8] <= di0[8*b +: 8];
            do0 <= mem[a0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction, called at posedge+1 while the DUT is in IDLE.
    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input logic [4:0] exp_a0, input logic [31:0] exp_rd);
        int lat;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        lat = 0;
        @(posedge clk); #1; lat = 1;
        chk({tag, " en0"}, {31'd0, en0}, 32'd1);
        chk({tag, " a0"}, {27'd0, a0}, {27'd0, exp_a0});
        chk({tag, " we0"}, {28'd0, we0}, w ? {28'd0, s} : 32'd0);
        if (w) chk({tag, " di0"}, di0, d);
        while (!ack && lat < 8) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, " ack_latency"}, lat, w ? 32'd2 : 32'd3);
        if (!w) chk({tag, " rdata"}, dat_o, exp_rd);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk({tag, " ack_single"}, {31'd0, ack}, 32'd0);
        $display("txn %s we=%0d adr=%h sel=%b dat_o=%h lat=%0d", tag, w, a, s, dat_o, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ack",  {31'd0, ack}, 32'd0);
        chk("reset dat_o", dat_o, 32'd0);
        chk("reset en0",  {31'd0, en0}, 32'd0);
        chk("reset we0",  {28'd0, we0}, 32'd0);
        chk("reset a0",   {27'd0, a0}, 32'd0);
        chk("reset di0",  di0, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-word writes then reads.
        txn("wr0", 1'b1, 32'h0, 4'hF, 32'hAA0055BB, 5'd0, 32'h0);
        txn("wr1", 1'b1, 32'h4, 4'hF, 32'hAA0055CC, 5'd1, 32'h0);
        txn("wr2", 1'b1, 32'h8, 4'hF, 32'hAA0055DD, 5'd2, 32'h0);
        txn("rd0", 1'b0, 32'h0, 4'hF, 32'h0, 5'd0, 32'hAA0055BB);
        txn("rd1", 1'b0, 32'h4, 4'hF, 32'h0, 5'd1, 32'hAA0055CC);
        txn("rd2", 1'b0, 32'h8, 4'hF, 32'h0, 5'd2, 32'hAA0055DD);

        // Byte-lane merges.
        txn("bw2", 1'b1, 32'h8, 4'b0001, 32'h00000033, 5'd2, 32'h0);
        txn("bw1", 1'b1, 32'h4, 4'b0010, 32'h00003300, 5'd1, 32'h0);
        txn("bw0", 1'b1, 32'h0, 4'b0100, 32'h00330000, 5'd0, 32'h0);
        txn("br0", 1'b0, 32'h0, 4'hF, 32'h0, 5'd0, 32'hAA3355BB);
        txn("br1", 1'b0, 32'h4, 4'hF, 32'h0, 5'd1, 32'hAA0033CC);
        txn("br2", 1'b0, 32'h8, 4'hF, 32'h0, 5'd2, 32'hAA005533);

        // Zero byte enables: acked, RAM unchanged, read data register untouched.
        txn("zw0", 1'b1, 32'h0, 4'b0000, 32'hFFFFFFFF, 5'd0, 32'h0);
        chk("zw0 dat_o_held", dat_o, 32'hAA005533);
        txn("zr0", 1'b0, 32'h0, 4'hF, 32'h0, 5'd0, 32'hAA3355BB);

        // Aliasing of upper address bits and ignored byte offset.
        txn("al80", 1'b0, 32'h80, 4'hF, 32'h0, 5'd0, 32'hAA3355BB);
        txn("al86", 1'b0, 32'h86, 4'hF, 32'h0, 5'd1, 32'hAA0033CC);

        // Held strobe: new address after ack starts exactly one new read.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
        @(posedge clk); #1;
        chk("hold a en0", {31'd0, en0}, 32'd1);
        @(posedge clk); #1;
        chk("hold a rdwait_ack", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("hold a ack", {31'd0, ack}, 32'd1);
        chk("hold a rdata", dat_o, 32'hAA3355BB);
        adr = 32'h8;
        @(posedge clk); #1;
        chk("hold idle ack", {31'd0, ack}, 32'd0);
        chk("hold idle en0", {31'd0, en0}, 32'd0);
        @(posedge clk); #1;
        chk("hold b en0", {31'd0, en0}, 32'd1);
        chk("hold b a0", {27'd0, a0}, 32'd2);
        @(posedge clk); #1;
        chk("hold b rdwait_ack", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("hold b ack", {31'd0, ack}, 32'd1);
        chk("hold b rdata", dat_o, 32'hAA005533);
        cyc = 1'b0; stb = 1'b0;
        begin
            int activity = 0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (en0 || ack) activity++;
            end
            chk("hold no_extra_txn", activity, 32'd0);
        end
        $display("txn hold two reads back-to-back dat_o=%h", dat_o);

        // Abort: cyc dropped in RDWAIT.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("abort no_ack", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        chk("abort idle", {30'd0, dut.state_reg}, {30'd0, IDLE});
        chk("abort dat_o", dat_o, 32'hAA0033CC);
        $display("txn abort read word1 dat_o=%h", dat_o);
        txn("post_abort_wr", 1'b1, 32'hC, 4'hF, 32'h12345678, 5'd3, 32'h0);
        txn("post_abort_rd", 1'b0, 32'hC, 4'hF, 32'h0, 5'd3, 32'h12345678);

        // Reset during ACCESS, before the RAM write edge.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; sel = 4'hF; dat_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("rstw en0_before", {31'd0, en0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw ack", {31'd0, ack}, 32'd0);
        chk("rstw dat_o", dat_o, 32'd0);
        chk("rstw en0", {31'd0, en0}, 32'd0);
        chk("rstw we0", {28'd0, we0}, 32'd0);
        chk("rstw a0", {27'd0, a0}, 32'd0);
        chk("rstw di0", di0, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("txn reset during write to word0");
        txn("rstw rd_old", 1'b0, 32'h0, 4'hF, 32'h0, 5'd0, 32'hAA3355BB);
        txn("rstw wr_again", 1'b1, 32'h0, 4'hF, 32'hDEADBEEF, 5'd0, 32'h0);
        txn("rstw rd_new", 1'b0, 32'h0, 4'hF, 32'h0, 5'd0, 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
